pipe_hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the five-stage f-d-e-m-w pipeline.
- Produces the per-stage cur_stall inputs of the pipeline registers and the forwarding selects for decode operands.
- Sequences the multi-cycle multiply/divide unit in execute, holding that stage until the result is ready.
- Issues a flush on an exception from memory stage; upstream stages back up through the existing allowin handshake.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/md_seq_fsm.sv | 73 +++++++
 rtl/pipe_hazard_ctrl.sv | 83 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned DIV_CYCLES_DEF = 33;
  localparam int unsigned MUL_CYCLES_DEF = 2;
  localparam int unsigned CNT_W_DEF      = 6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Operand source: a pending load-use forces the regfile path, E beats M.
  function automatic logic [1:0] fwd_sel(input logic load_use,
                                         input logic e_match,
                                         input logic e_load,
                                         input logic m_match);
    if (load_use)               return FWD_RF;
    else if (e_match && !e_load) return FWD_E;
    else if (m_match)           return FWD_M;
    else                        return FWD_RF;
  endfunction

endpackage

// File: rtl/md_seq_fsm.sv
// Multiply/divide sequencer: holds execute for the unit's latency, then
// presents the result until memory accepts it.
module md_seq_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_div_start,
  input  logic i_mul_start,
  input  logic i_exc_req,
  input  logic i_m_allowin,
  output logic o_md_busy,
  output logic o_md_done,
  output logic o_e_stall_c
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_load;

  assign w_load = i_div_start ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The start cycle is the first stall cycle, so BUSY lasts exactly the
  // loaded count and leaves as the counter reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_e_stall_c = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_div_start || i_mul_start) begin
          o_e_stall_c = 1'b1;
          w_cnt_nxt   = w_load;
          w_state_nxt = (w_load == '0) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        o_e_stall_c = 1'b1;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = MD_DONE;
      end
      MD_DONE: begin
        if (i_m_allowin) w_state_nxt = MD_IDLE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
    if (i_exc_req) begin
      w_state_nxt = MD_IDLE;
      w_cnt_nxt   = '0;
      o_e_stall_c = 1'b0;
    end
  end

  assign o_md_busy = (r_state == MD_BUSY);
  assign o_md_done = (r_state == MD_DONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, operand forwarding and stall/flush generation for the
// five-stage pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic       e_valid,
  input  logic [4:0] e_wreg_addr,
  input  logic       e_regen,
  input  logic [2:0] e_memtoreg,
  input  logic       e_mul_start,
  input  logic       e_div_start,
  input  logic       m_valid,
  input  logic [4:0] m_wreg_addr,
  input  logic       m_regen,
  input  logic       m_allowin,
  input  logic       m_data_wait,
  input  logic       exc_req,
  output logic       d_stall,
  output logic       e_stall,
  output logic       m_stall,
  output logic       flush,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy,
  output logic       md_done
);

  logic w_e_load;
  logic w_rs_e_match;
  logic w_rt_e_match;
  logic w_rs_m_match;
  logic w_rt_m_match;
  logic w_rs_luse;
  logic w_rt_luse;
  logic w_md_e_stall_c;

  // r0 is hardwired, so it never aliases a producer.
  assign w_e_load     = (e_memtoreg != 3'd0);
  assign w_rs_e_match = e_valid & e_regen & (d_rs != 5'd0) & (e_wreg_addr == d_rs);
  assign w_rt_e_match = e_valid & e_regen & (d_rt != 5'd0) & (e_wreg_addr == d_rt);
  assign w_rs_m_match = m_valid & m_regen & (d_rs != 5'd0) & (m_wreg_addr == d_rs);
  assign w_rt_m_match = m_valid & m_regen & (d_rt != 5'd0) & (m_wreg_addr == d_rt);

  assign w_rs_luse = d_valid & d_use_rs & w_rs_e_match & w_e_load;
  assign w_rt_luse = d_valid & d_use_rt & w_rt_e_match & w_e_load;

  assign fwd_rs_sel = fwd_sel(w_rs_luse, w_rs_e_match, w_e_load, w_rs_m_match);
  assign fwd_rt_sel = fwd_sel(w_rt_luse, w_rt_e_match, w_e_load, w_rt_m_match);

  // An exception releases every stall so the flush can sweep the pipe.
  assign flush   = exc_req;
  assign d_stall = (w_rs_luse | w_rt_luse) & ~exc_req;
  assign m_stall = m_data_wait & ~exc_req;
  assign e_stall = w_md_e_stall_c;

  md_seq_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq_fsm (
    .clk         (clk),
    .reset       (reset),
    .i_div_start (e_div_start),
    .i_mul_start (e_mul_start),
    .i_exc_req   (exc_req),
    .i_m_allowin (m_allowin),
    .o_md_busy   (md_busy),
    .o_md_done   (md_done),
    .o_e_stall_c (w_md_e_stall_c)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared against a phase-count model of the mul/div unit.
module tb_pipe_hazard_ctrl;

  localparam int DIV_N = 33;
  localparam int MUL_N = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid, d_use_rs, d_use_rt;
  logic [4:0] d_rs, d_rt;
  logic       e_valid, e_regen, e_mul_start, e_div_start;
  logic [4:0] e_wreg_addr;
  logic [2:0] e_memtoreg;
  logic       m_valid, m_regen, m_allowin, m_data_wait, exc_req;
  logic [4:0] m_wreg_addr;
  logic       d_stall, e_stall, m_stall, flush, md_busy, md_done;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int checks = 0;
  int failures = 0;
  int stall_seen, done_seen;

  // Model: an op is active from the cycle after its start; ph counts cycles
  // since the start cycle, n is the op's total execute occupancy.
  bit m_active;
  int m_ph, m_n;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .e_valid(e_valid), .e_wreg_addr(e_wreg_addr), .e_regen(e_regen),
    .e_memtoreg(e_memtoreg), .e_mul_start(e_mul_start), .e_div_start(e_div_start),
    .m_valid(m_valid), .m_wreg_addr(m_wreg_addr), .m_regen(m_regen),
    .m_allowin(m_allowin), .m_data_wait(m_data_wait), .exc_req(exc_req),
    .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall), .flush(flush),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy), .md_done(md_done)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit e_hit(input logic [4:0] r);
    return e_valid && e_regen && r != 5'd0 && e_wreg_addr == r;
  endfunction

  function automatic bit m_hit(input logic [4:0] r);
    return m_valid && m_regen && r != 5'd0 && m_wreg_addr == r;
  endfunction

  function automatic bit load_use(input logic [4:0] r, input logic used);
    return d_valid && used && e_hit(r) && e_memtoreg != 3'd0;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r, input logic used);
    if (load_use(r, used)) return 2'b00;
    if (e_hit(r) && e_memtoreg == 3'd0) return 2'b01;
    if (m_hit(r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic compare();
    bit eb, ed, es;
    if (!m_active) begin
      eb = 0;
      ed = 0;
      es = !exc_req && (e_div_start || e_mul_start);
    end else begin
      eb = (m_ph < m_n - 1);
      ed = !eb;
      es = eb && !exc_req;
    end
    chk("d_stall", 8'(d_stall),
        8'(!exc_req && (load_use(d_rs, d_use_rs) || load_use(d_rt, d_use_rt))));
    chk("e_stall", 8'(e_stall), 8'(es));
    chk("m_stall", 8'(m_stall), 8'(m_data_wait && !exc_req));
    chk("flush", 8'(flush), 8'(exc_req));
    chk("fwd_rs_sel", 8'(fwd_rs_sel), 8'(exp_fwd(d_rs, d_use_rs)));
    chk("fwd_rt_sel", 8'(fwd_rt_sel), 8'(exp_fwd(d_rt, d_use_rt)));
    chk("md_busy", 8'(md_busy), 8'(eb));
    chk("md_done", 8'(md_done), 8'(ed));
    stall_seen += int'(e_stall);
    done_seen  += int'(md_done);
  endtask

  task automatic advance();
    if (exc_req) m_active = 0;
    else if (!m_active) begin
      if (e_div_start || e_mul_start) begin
        m_active = 1;
        m_ph = 1;
        m_n = e_div_start ? DIV_N : MUL_N;
      end
    end else if (m_ph >= m_n - 1) begin
      if (m_allowin) m_active = 0;
    end else m_ph++;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic quiet();
    d_valid = 0; d_rs = 0; d_rt = 0; d_use_rs = 0; d_use_rt = 0;
    e_valid = 0; e_wreg_addr = 0; e_regen = 0; e_memtoreg = 0;
    e_mul_start = 0; e_div_start = 0;
    m_valid = 0; m_wreg_addr = 0; m_regen = 0;
    m_allowin = 1; m_data_wait = 0; exc_req = 0;
  endtask

  initial begin
    quiet();
    reset = 1;
    m_active = 0;
    stall_seen = 0;
    done_seen = 0;
    @(posedge clk);
    #1;
    chk("reset_md_busy", 8'(md_busy), 8'd0);
    chk("reset_md_done", 8'(md_done), 8'd0);
    chk("reset_e_stall", 8'(e_stall), 8'd0);
    reset = 0;
    cycle();

    // ALU result in E forwarded to rs
    d_valid = 1; d_rs = 3; d_use_rs = 1;
    e_valid = 1; e_regen = 1; e_wreg_addr = 3; e_memtoreg = 0;
    #1;
    chk("alu_fwd_rs", 8'(fwd_rs_sel), 8'd1);
    chk("alu_no_stall", 8'(d_stall), 8'd0);
    cycle();

    // Load-use on rt, then the load reaches M
    quiet();
    d_valid = 1; d_rt = 5; d_use_rt = 1;
    e_valid = 1; e_regen = 1; e_wreg_addr = 5; e_memtoreg = 3'd1;
    #1;
    chk("luse_stall", 8'(d_stall), 8'd1);
    chk("luse_rt_sel", 8'(fwd_rt_sel), 8'd0);
    cycle();
    e_valid = 0; e_regen = 0; e_memtoreg = 0;
    m_valid = 1; m_regen = 1; m_wreg_addr = 5;
    #1;
    chk("mfwd_rt_sel", 8'(fwd_rt_sel), 8'd2);
    chk("mfwd_no_stall", 8'(d_stall), 8'd0);
    cycle();

    // Divide with memory always accepting
    quiet();
    stall_seen = 0; done_seen = 0;
    e_div_start = 1;
    cycle();
    e_div_start = 0;
    repeat (40) cycle();
    chk("div_stall_cycles", 8'(stall_seen), 8'd32);
    chk("div_done_cycles", 8'(done_seen), 8'd1);
    e_div_start = 1;
    #1;
    chk("div2_start_stall", 8'(e_stall), 8'd1);
    cycle();
    e_div_start = 0;
    #1;
    chk("div2_busy", 8'(md_busy), 8'd1);
    repeat (36) cycle();

    // Multiply while memory refuses the result; start held high stays ignored
    stall_seen = 0; done_seen = 0;
    e_mul_start = 1; m_allowin = 0;
    cycle();
    repeat (5) cycle();
    chk("mul_stall_cycles", 8'(stall_seen), 8'd1);
    chk("mul_done_held", 8'(done_seen), 8'd5);
    m_allowin = 1; e_mul_start = 0;
    cycle();
    cycle();
    chk("mul_released", 8'(md_done), 8'd0);

    // Exception on the tenth cycle of a divide
    done_seen = 0;
    e_div_start = 1;
    cycle();
    e_div_start = 0;
    repeat (8) cycle();
    exc_req = 1; m_data_wait = 1;
    d_valid = 1; d_rs = 7; d_use_rs = 1;
    e_valid = 1; e_regen = 1; e_wreg_addr = 7; e_memtoreg = 3'd2;
    #1;
    chk("exc_flush", 8'(flush), 8'd1);
    chk("exc_e_stall", 8'(e_stall), 8'd0);
    chk("exc_d_stall", 8'(d_stall), 8'd0);
    chk("exc_m_stall", 8'(m_stall), 8'd0);
    cycle();
    quiet();
    #1;
    chk("exc_idle", 8'(md_busy), 8'd0);
    repeat (40) cycle();
    chk("exc_no_done", 8'(done_seen), 8'd0);

    // Exception coinciding with a divide start
    exc_req = 1; e_div_start = 1;
    cycle();
    quiet();
    #1;
    chk("exc_start_idle", 8'(md_busy), 8'd0);
    cycle();

    // r0 never forwards or stalls
    d_valid = 1; d_rs = 0; d_use_rs = 1;
    e_valid = 1; e_regen = 1; e_wreg_addr = 0; e_memtoreg = 3'd1;
    #1;
    chk("r0_sel", 8'(fwd_rs_sel), 8'd0);
    chk("r0_stall", 8'(d_stall), 8'd0);
    cycle();

    // Asynchronous reset in the middle of a divide
    quiet();
    e_div_start = 1;
    cycle();
    e_div_start = 0;
    cycle();
    chk("pre_reset_busy", 8'(md_busy), 8'd1);
    #1 reset = 1;
    #1;
    chk("async_reset_busy", 8'(md_busy), 8'd0);
    m_active = 0;
    #1 reset = 0;
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      d_valid     = 1'($urandom_range(0, 1));
      d_rs        = 5'($urandom_range(0, 3));
      d_rt        = 5'($urandom_range(0, 3));
      d_use_rs    = 1'($urandom_range(0, 1));
      d_use_rt    = 1'($urandom_range(0, 1));
      e_valid     = 1'($urandom_range(0, 1));
      e_regen     = 1'($urandom_range(0, 1));
      e_wreg_addr = 5'($urandom_range(0, 3));
      e_memtoreg  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      m_valid     = 1'($urandom_range(0, 1));
      m_regen     = 1'($urandom_range(0, 1));
      m_wreg_addr = 5'($urandom_range(0, 3));
      m_allowin   = ($urandom_range(0, 3) != 0);
      m_data_wait = 1'($urandom_range(0, 1));
      e_div_start = ($urandom_range(0, 24) == 0);
      e_mul_start = ($urandom_range(0, 9) == 0);
      exc_req     = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
